// File: rtl/grain128a_wide.sv
// Grain-128a keystream generator producing W keystream bits per clock behind a
// valid/ready output handshake; the 256-step initialisation takes 256/W cycles.
module grain128a_wide #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         initialise,
   input  logic [127:0] key,
   input  logic [95:0]  IV,
   input  logic         ks_ready,
   output logic         ks_valid,
   output logic [W-1:0] ks_data,
   output logic         ready
);

   localparam int INIT_CYCLES = 256 / W;
   localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   typedef struct packed {
      logic [127:0] s;
      logic [127:0] b;
      logic         y;
   } step_t;

   // One cipher clock; in init mode the pre-output bit is folded back into both registers.
   function automatic step_t grain_step(input logic [127:0] s, input logic [127:0] b,
                                        input logic init_mode);
      logic  f;
      logic  g;
      logic  h;
      logic  y;
      step_t r;
      f = s[0] ^ s[7] ^ s[38] ^ s[70] ^ s[81] ^ s[96];
      g = s[0] ^ b[0] ^ b[26] ^ b[56] ^ b[91] ^ b[96] ^ (b[3] & b[67]) ^ (b[11] & b[13]) ^
          (b[17] & b[18]) ^ (b[27] & b[59]) ^ (b[40] & b[48]) ^ (b[61] & b[65]) ^
          (b[68] & b[84]) ^ (b[88] & b[92] & b[93] & b[95]) ^ (b[22] & b[24] & b[25]) ^
          (b[70] & b[78] & b[82]);
      h = (b[12] & s[8]) ^ (s[13] & s[20]) ^ (b[95] & s[42]) ^ (s[60] & s[79]) ^
          (b[12] & b[95] & s[94]);
      y = h ^ s[93] ^ b[2] ^ b[15] ^ b[36] ^ b[45] ^ b[64] ^ b[73] ^ b[89];
      r.s = {f ^ (y & init_mode), s[127:1]};
      r.b = {g ^ (y & init_mode), b[127:1]};
      r.y = y;
      return r;
   endfunction

   logic [127:0] lfsr_r;
   logic [127:0] nfsr_r;
   logic [1:0]   state_r;
   logic [CNT_W-1:0] cnt_r;
   logic         ks_valid_r;
   logic [W-1:0] ks_data_r;
   logic         ready_r;

   logic [127:0] lfsr_nxt_s;
   logic [127:0] nfsr_nxt_s;
   logic [W-1:0] word_s;
   step_t        step_s;
   logic         init_mode_s;
   logic         advance_s;

   assign init_mode_s = (state_r == ST_INIT);
   assign advance_s   = !ks_valid_r || ks_ready;

   // W chained steps; step i sees the state produced by step i-1, bit 0 is earliest
   always_comb begin
      lfsr_nxt_s = lfsr_r;
      nfsr_nxt_s = nfsr_r;
      word_s     = '0;
      step_s     = '0;
      for (int i = 0; i < W; i++) begin
         step_s     = grain_step(lfsr_nxt_s, nfsr_nxt_s, init_mode_s);
         lfsr_nxt_s = step_s.s;
         nfsr_nxt_s = step_s.b;
         word_s[i]  = step_s.y;
      end
   end

   // Load, initialisation sequencing and stall-aware keystream output
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         lfsr_r     <= '0;
         nfsr_r     <= '0;
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         ks_valid_r <= 1'b0;
         ks_data_r  <= '0;
         ready_r    <= 1'b0;
      end else if (initialise) begin
         nfsr_r     <= key;
         lfsr_r     <= {1'b0, {31{1'b1}}, IV};
         cnt_r      <= '0;
         state_r    <= ST_INIT;
         ks_valid_r <= 1'b0;
         ready_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               lfsr_r <= lfsr_nxt_s;
               nfsr_r <= nfsr_nxt_s;
               cnt_r  <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_LAST) begin
                  state_r <= ST_RUN;
                  ready_r <= 1'b1;
               end
            end
            ST_RUN: begin
               // a pending word is only replaced once the consumer has taken it
               if (advance_s) begin
                  lfsr_r     <= lfsr_nxt_s;
                  nfsr_r     <= nfsr_nxt_s;
                  ks_data_r  <= word_s;
                  ks_valid_r <= 1'b1;
               end
            end
            ST_IDLE: begin
               ks_valid_r <= 1'b0;
               ready_r    <= 1'b0;
            end
            default: begin
               state_r    <= ST_IDLE;
               ks_valid_r <= 1'b0;
               ready_r    <= 1'b0;
            end
         endcase
      end
   end

   assign ks_valid = ks_valid_r;
   assign ks_data  = ks_data_r;
   assign ready    = ready_r;

endmodule

// File: tb/tb_grain128a_wide.sv
// Bench for grain128a_wide: W=8, W=1 and W=32 instances share key/IV/initialise and are
// compared against a time-indexed Grain-128a sequence model.
module tb_grain128a_wide;

   localparam int NBITS = 8192;
   localparam int MLEN  = 128 + 256 + NBITS;

   logic         clk;
   logic         n_reset;
   logic         initialise;
   logic [127:0] key;
   logic [95:0]  iv;
   logic         rdy8, rdy1, rdy32;
   logic         v8, v1, v32;
   logic         r8, r1, r32;
   logic [7:0]   d8;
   logic [0:0]   d1;
   logic [31:0]  d32;

   grain128a_wide #(.W(8)) dut8 (
      .clk(clk), .n_reset(n_reset), .initialise(initialise), .key(key), .IV(iv),
      .ks_ready(rdy8), .ks_valid(v8), .ks_data(d8), .ready(r8));
   grain128a_wide #(.W(1)) dut1 (
      .clk(clk), .n_reset(n_reset), .initialise(initialise), .key(key), .IV(iv),
      .ks_ready(rdy1), .ks_valid(v1), .ks_data(d1), .ready(r1));
   grain128a_wide #(.W(32)) dut32 (
      .clk(clk), .n_reset(n_reset), .initialise(initialise), .key(key), .IV(iv),
      .ks_ready(rdy32), .ks_valid(v32), .ks_data(d32), .ready(r32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  vld_o, rdy_o;
   logic [31:0] dat_o [3];
   assign vld_o = {v32, v1, v8};
   assign rdy_o = {r32, r1, r8};
   assign dat_o[0] = {24'd0, d8};
   assign dat_o[1] = {31'd0, d1};
   assign dat_o[2] = d32;

   int n_cmp = 0;
   int n_bad = 0;
   int edge_k = 0;
   int wid [3] = '{8, 1, 32};
   int idx [3];
   int first_rdy [3];
   int first_val [3];
   logic [31:0] first_word [3];
   logic [31:0] held [3];
   bit hold_pend [3];

   // Reference sequences indexed by cipher time rather than by register position
   bit ms [0:MLEN-1];
   bit mb [0:MLEN-1];
   bit mz [0:NBITS-1];

   task automatic run_model(input logic [127:0] k, input logic [95:0] v);
      bit f, g, h, y;
      for (int t = 0; t < 128; t++) begin
         mb[t] = k[t];
         if (t < 96) ms[t] = v[t];
         else if (t < 127) ms[t] = 1'b1;
         else ms[t] = 1'b0;
      end
      for (int t = 0; t < 256 + NBITS; t++) begin
         f = ms[t] ^ ms[t+7] ^ ms[t+38] ^ ms[t+70] ^ ms[t+81] ^ ms[t+96];
         g = ms[t] ^ mb[t] ^ mb[t+26] ^ mb[t+56] ^ mb[t+91] ^ mb[t+96] ^ (mb[t+3] & mb[t+67]) ^
             (mb[t+11] & mb[t+13]) ^ (mb[t+17] & mb[t+18]) ^ (mb[t+27] & mb[t+59]) ^
             (mb[t+40] & mb[t+48]) ^ (mb[t+61] & mb[t+65]) ^ (mb[t+68] & mb[t+84]) ^
             (mb[t+88] & mb[t+92] & mb[t+93] & mb[t+95]) ^ (mb[t+22] & mb[t+24] & mb[t+25]) ^
             (mb[t+70] & mb[t+78] & mb[t+82]);
         h = (mb[t+12] & ms[t+8]) ^ (ms[t+13] & ms[t+20]) ^ (mb[t+95] & ms[t+42]) ^
             (ms[t+60] & ms[t+79]) ^ (mb[t+12] & mb[t+95] & ms[t+94]);
         y = h ^ ms[t+93] ^ mb[t+2] ^ mb[t+15] ^ mb[t+36] ^ mb[t+45] ^ mb[t+64] ^
             mb[t+73] ^ mb[t+89];
         if (t < 256) begin
            ms[t+128] = f ^ y;
            mb[t+128] = g ^ y;
         end else begin
            ms[t+128] = f;
            mb[t+128] = g;
            mz[t-256] = y;
         end
      end
   endtask

   function automatic logic [31:0] exp_word(input int start, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = mz[start+i];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_k);
      end
   endtask

   // One cycle: called just after a falling edge, leaves just after the next falling edge
   task automatic cycle_check(input bit bp);
      logic [2:0] cons;
      for (int d = 0; d < 3; d++) begin
         if (hold_pend[d]) begin
            check($sformatf("stall_hold_w%0d", wid[d]), {31'd0, vld_o[d], dat_o[d]},
                  {31'd0, 1'b1, held[d]});
            hold_pend[d] = 1'b0;
         end
         if (rdy_o[d] && first_rdy[d] < 0) first_rdy[d] = edge_k;
         if (vld_o[d] && first_val[d] < 0) begin
            first_val[d]  = edge_k;
            first_word[d] = dat_o[d];
         end
      end
      rdy8 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cons = {rdy32, rdy1, rdy8};
      for (int d = 0; d < 3; d++) begin
         if (vld_o[d]) begin
            if (cons[d]) begin
               if ((idx[d] + 1) * wid[d] <= NBITS)
                  check($sformatf("stream_w%0d_word%0d", wid[d], idx[d]), {32'd0, dat_o[d]},
                        {32'd0, exp_word(idx[d] * wid[d], wid[d])});
               idx[d]++;
            end else begin
               hold_pend[d] = 1'b1;
               held[d]      = dat_o[d];
            end
         end
      end
      @(posedge clk);
      edge_k++;
      @(negedge clk);
   endtask

   // Enters and leaves just after a falling edge; the last high edge becomes E0
   task automatic load(input logic [127:0] k, input logic [95:0] v, input int hold);
      key = k;
      iv = v;
      initialise = 1'b1;
      rdy8 = 1'b1;
      repeat (hold) @(posedge clk);
      edge_k = 0;
      @(negedge clk);
      initialise = 1'b0;
      key = {$urandom, $urandom, $urandom, $urandom};
      iv = {$urandom, $urandom, $urandom};
   endtask

   typedef struct {
      logic [127:0] key;
      logic [95:0]  iv;
      bit           bp;
      int           pre;
      int           hold;
      int           words8;
      int           rdy8e, val8e, rdy1e, val1e, rdy32e, val32e;
      logic [31:0]  first32;
   } vec_t;

   vec_t tbl [4];
   logic [127:0] gold_key, rkey;
   logic [95:0]  gold_iv;
   int  cyc;
   bit  done;

   initial begin
      gold_key = 128'h786477e1dc256ca0f2d71da33e3a6042;
      gold_iv  = 96'h32a4ba0884bd27d3120878f2;
      rkey     = {$urandom, $urandom, $urandom, $urandom};
      tbl[0] = '{gold_key, gold_iv, 1'b0, 0, 1, 64, 32, 33, 256, 257, 8, 9, 32'd0};
      tbl[1] = '{rkey, {$urandom, $urandom, $urandom}, 1'b1, 0, 1, 1000, 32, 33, 256, 257, 8, 9, 32'd0};
      tbl[2] = '{rkey, {$urandom, $urandom, $urandom}, 1'b0, 10, 1, 64, 32, 33, 256, 257, 8, 9, 32'd0};
      tbl[3] = '{gold_key, {$urandom, $urandom, $urandom}, 1'b0, 0, 3, 64, 32, 33, 256, 257, 8, 9, 32'd0};
      for (int r = 0; r < 4; r++) begin
         run_model(tbl[r].key, tbl[r].iv);
         tbl[r].first32 = exp_word(0, 32);
      end

      n_reset = 1'b0;
      initialise = 1'b0;
      key = '0;
      iv = '0;
      rdy8 = 1'b1;
      rdy1 = 1'b1;
      rdy32 = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_flags", {58'd0, vld_o, rdy_o}, 64'd0);
      check("reset_data8_1", {32'd0, dat_o[0][7:0], 24'd0, dat_o[1]}, 64'd0);
      check("reset_data32", {32'd0, dat_o[2]}, 64'd0);
      n_reset = 1'b1;
      @(negedge clk);

      for (int r = 0; r < 4; r++) begin
         run_model(tbl[r].key, tbl[r].iv);
         if (r > 0) check("valid_before_reload", {63'd0, vld_o[0]}, 64'd1);
         if (tbl[r].pre > 0) begin
            load(tbl[r].key, ~tbl[r].iv, 1);
            repeat (tbl[r].pre) @(negedge clk);
         end
         load(tbl[r].key, tbl[r].iv, tbl[r].hold);
         check("load_clears_flags", {58'd0, vld_o, rdy_o}, 64'd0);
         for (int d = 0; d < 3; d++) begin
            idx[d] = 0;
            first_rdy[d] = -1;
            first_val[d] = -1;
            first_word[d] = '0;
            hold_pend[d] = 1'b0;
         end
         cyc = 0;
         done = 1'b0;
         while (!done && cyc < 4000) begin
            cycle_check(tbl[r].bp);
            cyc++;
            done = (idx[0] >= tbl[r].words8) && (idx[1] >= 512) && (idx[2] >= 16);
         end
         check($sformatf("row%0d_budget", r), {63'd0, done}, 64'd1);
         check($sformatf("row%0d_ready_w8", r), 64'(first_rdy[0]), 64'(tbl[r].rdy8e));
         check($sformatf("row%0d_valid_w8", r), 64'(first_val[0]), 64'(tbl[r].val8e));
         check($sformatf("row%0d_ready_w1", r), 64'(first_rdy[1]), 64'(tbl[r].rdy1e));
         check($sformatf("row%0d_valid_w1", r), 64'(first_val[1]), 64'(tbl[r].val1e));
         check($sformatf("row%0d_ready_w32", r), 64'(first_rdy[2]), 64'(tbl[r].rdy32e));
         check($sformatf("row%0d_valid_w32", r), 64'(first_val[2]), 64'(tbl[r].val32e));
         check($sformatf("row%0d_first32", r), {32'd0, first_word[2]}, {32'd0, tbl[r].first32});
      end

      // asynchronous reset mid-stream, then idle without a new load
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      check("async_reset_flags", {58'd0, vld_o, rdy_o}, 64'd0);
      check("async_reset_data", {23'd0, dat_o[0][7:0], dat_o[1][0], dat_o[2]}, 64'd0);
      @(negedge clk);
      n_reset = 1'b1;
      for (int c = 0; c < 110; c++) begin
         @(negedge clk);
         check("idle_after_reset", {17'd0, vld_o, rdy_o, dat_o[0][7:0], dat_o[1][0], dat_o[2]},
               64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/grain128a_wide.md
# grain128a_wide

Parametrised Grain-128a keystream generator that produces `W` keystream bits per clock instead of one, with a valid/ready output handshake so downstream consumers can stall it. It is the successor to the single-bit `grain_128a` core and sits between the key/IV setup logic and the XOR/cipher datapath. It unrolls the LFSR/NFSR update `W` times per cycle, runs the 256-step initialisation in `256/W` cycles, and holds state while the consumer back-pressures.

## Interface
- `W`, default 8: keystream bits per cycle. Legal values: 1, 2, 4, 8, 16, 32. Must divide 256.
- `clk`  in  1: single clock; all state on its rising edge.
- `n_reset`  in  1: asynchronous, active-low reset.
- `initialise`  in  1: one-cycle start pulse. Samples `key`/`IV` and restarts from any state.
- `key`  in  128: secret key; `key[0]` is key bit k0.
- `IV`  in  96: initialisation vector; `IV[0]` is IV bit 0.
- `ks_ready`  in  1: consumer accepts `ks_data` this cycle.
- `ks_valid`  out  1: `ks_data` holds a fresh word.
- `ks_data`  out  W: keystream word; bit 0 is the earliest-generated bit.
- `ready`  out  1: initialisation complete, core in RUN.

## Operation
- **State registers:**
  - 128-bit LFSR `s`, 128-bit NFSR `b`.
  - FSM {IDLE, INIT, RUN}.
  - Init counter, `$clog2(256/W)` bits.
- **One Grain step** (applied `W` times combinationally per advancing cycle; step i uses the state after step i-1):
  - f = s0^s7^s38^s70^s81^s96
  - g = s0^b0^b26^b56^b91^b96^b3b67^b11b13^b17b18^b27b59^b40b48^b61b65^b68b84^b88b92b93b95^b22b24b25^b70b78b82
  - h = b12s8^s13s20^b95s42^s60s79^b12b95s94
  - y = h^s93^b2^b15^b36^b45^b64^b73^b89
  - Shift both registers down by one: s127←f (INIT: f^y), b127←g (INIT: g^y).
- **Load** (edge sampling `initialise`=1, any state):
  - b ← key.
  - s[95:0] ← IV, s[126:96] ← all ones, s[127] ← 0.
  - Counter ← 0, FSM ← INIT, `ks_valid` ← 0, `ready` ← 0.
- **INIT:**
  - Each cycle performs `W` init steps (y fed back, no output) and increments the counter.
  - On the edge where the counter equals 256/W−1: FSM ← RUN, `ready` ← 1.
- **RUN:**
  - Advance condition: `!ks_valid || ks_ready`.
  - On advance: `W` keystream steps; `ks_data[i]` ← y of step i; `ks_valid` ← 1.
  - When not advancing, LFSR, NFSR and `ks_data` hold unchanged. No bit is lost or duplicated across stalls.
- **IDLE:** registers hold, `ks_valid`=0, `ready`=0. Stays in IDLE until `initialise`.
- **Priority:** `initialise` overrides everything. A word pending with `ks_valid` is discarded even if `ks_ready`=1 on that edge.
- Keystream mode only; authentication-tag mode is out of scope.

## Timing
- **Reset values:** `ks_valid`=0, `ks_data`=0, `ready`=0, FSM=IDLE, LFSR=0, NFSR=0, counter=0.
- **Reset mid-INIT or mid-RUN:** all of the above apply immediately (asynchronous). Restart requires a new `initialise`.
- **Cycle timeline** (E0 = edge sampling `initialise`=1):
  - INIT occupies edges E1..E(256/W).
  - `ready` rises after E(256/W).
  - First `ks_valid` rises after E(256/W+1).
  - W=8: `ready` after E32, first word after E33. W=1: after E256 and E257.
- **Throughput:** one W-bit word per cycle while `ks_ready`=1. Accept on the edge where `ks_valid && ks_ready`.
- `ks_data` and `ks_valid` are registered outputs. No combinational path from `ks_ready` to them.
- `initialise` held high for several cycles reloads on every edge. INIT starts counting after it drops.
- Inputs `key`/`IV` are sampled only on the load edge.

## Test plan
- **Reset/idle:** assert `n_reset`=0 mid-stream, then release with no `initialise` → `ks_valid`=0, `ready`=0, `ks_data`=0 held for ≥100 cycles.
- **Golden stream:** W=8, key=128'h786477e1dc256ca0f2d71da33e3a6042, IV=96'h32a4ba0884bd27d3120878f2, `ks_ready`=1 → `ready` after E32, first word after E33. First 256 bits match the bit-serial reference model (and the existing `grain_128a` `key_stream` output) bit-for-bit, LSB first.
- **Width equivalence:** same key/IV with W=1, 4, 32 → identical 512-bit stream. First `ks_valid` after E257, E65, E9 respectively.
- **Back-pressure:** random `ks_ready` (~50% duty) for 1000 words → accepted-word sequence equals the no-stall stream. `ks_data` stable whenever `ks_valid && !ks_ready`.
- **Re-initialise mid-RUN:** pulse `initialise` with a new IV while `ks_valid`=1 and `ks_ready`=1 → `ks_valid`=0 and `ready`=0 on the next cycle. After 256/W+1 edges the stream matches the golden stream for the new IV.
- **Re-initialise mid-INIT:** pulse `initialise` at INIT counter=10 → INIT restarts from 0. Timing and stream are identical to a clean start.
